// File: rtl/sw_load_ctrl.sv
// Load-side controller for the switch register: synchronizes switches and the load
// button, debounces the button and issues one registered load strobe per press.
module sw_load_ctrl #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_load,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] data_out,
    output logic             ld_out,
    output logic             busy,
    output logic [7:0]       ld_count
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        PULSE,
        WAIT_REL,
        DEB_REL
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             btn_meta_reg;
    logic             btn_s_reg;
    logic [WIDTH-1:0] sw_meta_reg;
    logic [WIDTH-1:0] sw_s_reg;
    logic [WIDTH-1:0] data_reg;
    logic             ld_reg;
    logic             busy_reg;
    logic [7:0]       count_reg;

    // Two-flop synchronizers; everything downstream sees only btn_s_reg / sw_s_reg.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta_reg <= 1'b0;
            btn_s_reg    <= 1'b0;
            sw_meta_reg  <= '0;
            sw_s_reg     <= '0;
        end else begin
            btn_meta_reg <= btn_load;
            btn_s_reg    <= btn_meta_reg;
            sw_meta_reg  <= sw_raw;
            sw_s_reg     <= sw_meta_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            data_reg  <= '0;
            ld_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            count_reg <= 8'd0;
        end else begin
            ld_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (btn_s_reg) begin
                        state_reg <= DEB_PRESS;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                DEB_PRESS: begin
                    if (!btn_s_reg) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                    end else if (cnt_reg == CNT_LAST) begin
                        // Strobe, capture and count all land on the edge entering PULSE.
                        state_reg <= PULSE;
                        cnt_reg   <= '0;
                        ld_reg    <= 1'b1;
                        data_reg  <= sw_s_reg;
                        count_reg <= count_reg + 8'd1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                PULSE: begin
                    state_reg <= WAIT_REL;
                    cnt_reg   <= '0;
                end
                WAIT_REL: begin
                    if (!btn_s_reg) begin
                        state_reg <= DEB_REL;
                        cnt_reg   <= '0;
                    end
                end
                DEB_REL: begin
                    if (btn_s_reg) begin
                        state_reg <= WAIT_REL;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out = data_reg;
    assign ld_out   = ld_reg;
    assign busy     = busy_reg;
    assign ld_count = count_reg;

endmodule

// File: tb/tb_sw_load_ctrl.sv
// Scoreboard bench for sw_load_ctrl with a short debounce: each expected strobe is
// queued when its press is driven and checked when ld_out fires.
module tb_sw_load_ctrl;

    localparam int WIDTH = 8;
    localparam int DEB   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             btn_load;
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] data_out;
    logic             ld_out;
    logic             busy;
    logic [7:0]       ld_count;

    typedef struct {
        logic [7:0] data;
        logic [7:0] count;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] exp_count = 8'd0;
    int         checks    = 0;
    int         failures  = 0;
    logic       prev_ld   = 1'b0;

    sw_load_ctrl #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_load (btn_load),
        .sw_raw   (sw_raw),
        .data_out (data_out),
        .ld_out   (ld_out),
        .busy     (busy),
        .ld_count (ld_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Strobe monitor: every ld_out cycle must match the oldest queued expectation.
    always @(negedge clk) begin
        if (ld_out) begin
            if (prev_ld)
                check("double_strobe", 32'(prev_ld), 32'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("strobe_data", 32'(data_out), 32'(e.data));
                check("strobe_count", 32'(ld_count), 32'(e.count));
                $display("strobe data=0x%02h count=%0d", data_out, ld_count);
            end
        end
        prev_ld <= ld_out;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_strobe(input logic [7:0] val);
        exp_t e;
        exp_count = exp_count + 8'd1;
        e.data  = val;
        e.count = exp_count;
        sb_q.push_back(e);
    endtask

    task automatic wait_idle(input string tag);
        int i;
        i = 0;
        while (busy && i < 300) begin
            tick(1);
            i++;
        end
        tick(2);
        @(negedge clk);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_drain"}, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic press(input logic [7:0] val, input int hold, input string tag);
        sw_raw = val;
        tick(3);
        expect_strobe(val);
        btn_load = 1'b1;
        tick(hold);
        btn_load = 1'b0;
        wait_idle(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        btn_load = 1'b0;
        sw_raw   = 8'h00;
        tick(3);
        @(negedge clk);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_ld", 32'(ld_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(ld_count), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(2);

        // Glitch: 3 edges of button high must not produce a strobe.
        sw_raw = 8'h11;
        tick(3);
        btn_load = 1'b1;
        tick(3);
        btn_load = 1'b0;
        tick(6);
        @(negedge clk);
        check("glitch_busy", 32'(busy), 32'd0);
        check("glitch_count", 32'(ld_count), 32'd0);
        check("glitch_ld", 32'(ld_out), 32'd0);
        $display("glitch press done");

        // Clean press: strobe in the cycle after edge k+6 (k = first edge sampling the button).
        sw_raw = 8'hA5;
        tick(3);
        expect_strobe(8'hA5);
        btn_load = 1'b1;
        tick(6);
        @(negedge clk);
        check("clean_pre_strobe", 32'(ld_out), 32'd0);
        tick(1);
        @(negedge clk);
        check("clean_strobe", 32'(ld_out), 32'd1);
        check("clean_data", 32'(data_out), 32'hA5);
        check("clean_count", 32'(ld_count), 32'd1);
        tick(4);
        btn_load = 1'b0;
        wait_idle("clean");

        // Long hold followed by 2-cycle release bounces: still one strobe.
        sw_raw = 8'h5A;
        tick(3);
        expect_strobe(8'h5A);
        btn_load = 1'b1;
        tick(100);
        for (int b = 0; b < 2; b++) begin
            btn_load = 1'b0;
            tick(2);
            btn_load = 1'b1;
            tick(2);
        end
        btn_load = 1'b0;
        // Release seen by the FSM at edge +3, four more debounce edges return it to IDLE.
        tick(5);
        @(negedge clk);
        check("bounce_busy_hold", 32'(busy), 32'd1);
        tick(2);
        @(negedge clk);
        check("bounce_busy_fall", 32'(busy), 32'd0);
        check("bounce_count", 32'(ld_count), 32'd2);
        wait_idle("bounce");

        // Switch movement without a press leaves data_out untouched.
        press(8'h3C, 10, "load_3c");
        sw_raw = 8'hFF;
        tick(20);
        @(negedge clk);
        check("data_hold", 32'(data_out), 32'h3C);
        press(8'hFF, 10, "load_ff");
        check("data_new", 32'(data_out), 32'hFF);

        // Reset while in DEB_PRESS with cnt=2 aborts the press.
        sw_raw = 8'h77;
        tick(3);
        btn_load = 1'b1;
        tick(5);
        @(negedge clk);
        check("midrst_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        tick(1);
        rst       = 1'b0;
        btn_load  = 1'b0;
        exp_count = 8'd0;
        @(negedge clk);
        check("midrst_ld", 32'(ld_out), 32'd0);
        check("midrst_data", 32'(data_out), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_count", 32'(ld_count), 32'd0);
        tick(20);
        @(negedge clk);
        check("midrst_no_strobe", 32'(ld_count), 32'd0);
        check("midrst_idle", 32'(busy), 32'd0);
        $display("mid-operation reset done");

        // 256 presses wrap the counter back to zero.
        for (int n = 0; n < 256; n++)
            press(8'(n), 8, "wrap");
        check("wrap_count", 32'(ld_count), 32'd0);
        check("wrap_data", 32'(data_out), 32'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
